// File: rtl/pc_seq_irq_if.sv
// rtl/pc_seq_irq_if.sv - control/status bundle between decode stages and the PC sequencer
interface pc_seq_irq_if #(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 8,
  parameter int NUM_IRQ     = 4
) ();
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic              pause;
  logic              goto;
  logic [ADDR_W-1:0] goto_addr;
  logic              call;
  logic              skip;
  logic              ret;
  logic              reti;
  logic [NUM_IRQ-1:0] irq;
  logic [NUM_IRQ-1:0] irq_ack;
  logic              save_accum;
  logic              in_isr;
  logic [ADDR_W-1:0] pc_out;
  logic              kill;
  logic [LVL_W-1:0]  stack_level;
  logic              error;
  logic [1:0]        err_code;
  logic              stopped;

  modport master (
    output pause, goto, goto_addr, call, skip, ret, reti, irq,
    input  irq_ack, save_accum, in_isr, pc_out, kill, stack_level, error, err_code, stopped
  );

  modport slave (
    input  pause, goto, goto_addr, call, skip, ret, reti, irq,
    output irq_ack, save_accum, in_isr, pc_out, kill, stack_level, error, err_code, stopped
  );
endinterface

// File: rtl/pc_seq_irq.sv
// rtl/pc_seq_irq.sv - fetch PC sequencer with return stack and vectored interrupt entry
module pc_seq_irq #(
  parameter int ADDR_W        = 12,
  parameter int STACK_DEPTH   = 8,
  parameter int NUM_IRQ       = 4,
  parameter int VECTOR_BASE   = 4,
  parameter int VECTOR_STRIDE = 4
) (
  input logic         clk,
  input logic         reset,
  pc_seq_irq_if.slave seq
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SEL_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_WAIT,
    ST_SAVE,
    ST_STOPWAIT,
    ST_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        ks_q, ks_d;
  logic              gie_q, gie_d;
  logic              error_q, error_d;
  logic              stopped_q, stopped_d;
  logic [1:0]        code_q, code_d;
  logic [LVL_W-1:0]  level_q;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic              push, pop, full, empty, pend, hold, save_pulse;
  logic [ADDR_W-1:0] top, pc_inc, vector;
  logic [LVL_W-1:0]  level_m1;
  logic [SEL_W-1:0]  sel;

  assign hold     = seq.pause | stopped_q;
  assign pend     = (|seq.irq) & gie_q;
  assign full     = (level_q == LVL_W'(STACK_DEPTH));
  assign empty    = (level_q == '0);
  assign level_m1 = level_q - LVL_W'(1);
  assign top      = stack_q[level_m1[PTR_W-1:0]];
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign vector   = ADDR_W'(VECTOR_BASE + int'(sel) * VECTOR_STRIDE);

  // Lowest index wins; a request that vanished before entry falls back to line 0.
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (seq.irq[i]) sel = SEL_W'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ks_d       = ks_q;
    gie_d      = gie_q;
    error_d    = error_q;
    code_d     = code_q;
    stopped_d  = stopped_q;
    push       = 1'b0;
    pop        = 1'b0;
    save_pulse = 1'b0;
    if (!hold) begin
      if (state_q == ST_SAVE) begin
        if (full) begin
          error_d   = 1'b1;
          code_d    = 2'd1;
          stopped_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          push       = 1'b1;
          pc_d       = vector;
          save_pulse = 1'b1;
          gie_d      = 1'b0;
          ks_d       = {ks_q[0], 1'b1};
          state_d    = ST_RUN;
        end
      end else if (state_q == ST_WAIT) begin
        if (seq.skip && !ks_q[1]) pc_d = pc_inc;
        ks_d    = {ks_q[0], 1'b1};
        state_d = ST_SAVE;
      end else if (seq.skip && !ks_q[1]) begin
        if (pend) begin
          ks_d    = 2'b11;
          state_d = ST_SAVE;
        end else begin
          ks_d = 2'b10;
          pc_d = pc_inc;
        end
      end else if (seq.goto && !ks_q[0]) begin
        if (seq.call && full) begin
          error_d   = 1'b1;
          code_d    = 2'd1;
          stopped_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          push = seq.call;
          pc_d = seq.goto_addr;
          ks_d = {ks_q[0], 1'b1};
          if (pend) state_d = ST_SAVE;
        end
      end else if (seq.ret && !ks_q[0]) begin
        if (empty) begin
          if (seq.reti) begin
            error_d   = 1'b1;
            code_d    = 2'd2;
            stopped_d = 1'b1;
            state_d   = ST_HALT;
          end else begin
            state_d = ST_STOPWAIT;
          end
        end else begin
          pop  = 1'b1;
          pc_d = top;
          if (seq.reti) gie_d = 1'b1;
          ks_d = {ks_q[0], 1'b1};
          // pend was formed from the gie held before this reti
          if (pend) state_d = ST_SAVE;
        end
      end else if (state_q == ST_STOPWAIT) begin
        stopped_d = 1'b1;
        state_d   = ST_HALT;
      end else if (pend) begin
        ks_d    = {ks_q[0], 1'b1};
        state_d = ST_WAIT;
      end else begin
        pc_d = pc_inc;
        ks_d = {ks_q[0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      pc_q      <= '0;
      ks_q      <= 2'b11;
      gie_q     <= 1'b1;
      error_q   <= 1'b0;
      code_q    <= 2'd0;
      stopped_q <= 1'b0;
      level_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ks_q      <= ks_d;
      gie_q     <= gie_d;
      error_q   <= error_d;
      code_q    <= code_d;
      stopped_q <= stopped_d;
      if (push) begin
        level_q <= level_q + LVL_W'(1);
      end else if (pop) begin
        level_q <= level_m1;
      end
    end
  end

  // Entries need no reset: level_q alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push && !reset) stack_q[level_q[PTR_W-1:0]] <= pc_q;
  end

  assign seq.pc_out      = pc_q;
  assign seq.kill        = ks_q[1];
  assign seq.in_isr      = ~gie_q;
  assign seq.stack_level = level_q;
  assign seq.error       = error_q;
  assign seq.err_code    = code_q;
  assign seq.stopped     = stopped_q;
  assign seq.save_accum  = save_pulse;
  assign seq.irq_ack     = save_pulse ? (NUM_IRQ'(1) << sel) : '0;
endmodule
